// File: rtl/mixer_seq_pkg.sv
// Shared types and constants for the mixer mask sequencer.
package mixer_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    PENDING = 2'd2,
    APPLY   = 2'd3
  } state_e;

  localparam int NUM_WAVES = 3;

  typedef logic [NUM_WAVES-1:0] mask_t;

  // Bit positions inside a mask: {triangle, sawtooth, square}
  localparam int SQ  = 0;
  localparam int SAW = 1;
  localparam int TRI = 2;

  // Slot that follows cur; wraps to 0 once cur has reached (or passed) the last active slot
  function automatic logic [1:0] next_slot(input logic [1:0] cur, input logic [1:0] last);
    return (cur >= last) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/mixer_mask_table.sv
// Mask table: NUM_SLOTS x 3-bit register file, one write port, one combinational read port.
module mixer_mask_table
  import mixer_seq_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  mask_t            i_wr_mask,
  input  logic [IDX_W-1:0] i_rd_idx,
  output mask_t            o_rd_mask
);

  logic [NUM_SLOTS-1:0][NUM_WAVES-1:0] w_slots;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      mask_t r_mask;

      // One slot: cleared by reset, loaded when the write targets this index
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_mask <= '0;
        end else if (i_wr_en && (i_wr_idx == IDX_W'(gi))) begin
          r_mask <= i_wr_mask;
        end
      end

      assign w_slots[gi] = r_mask;
    end
  endgenerate

  // Read returns the pre-write contents during a same-cycle write
  assign o_rd_mask = w_slots[i_rd_idx];

endmodule

// File: rtl/mixer_mask_sequencer.sv
// Steps the mixer enables through the mask table, deferring each change to a phase wrap.
module mixer_mask_sequencer
  import mixer_seq_pkg::*;
#(
  parameter int          NUM_SLOTS    = 4,
  parameter int          STEP_W       = 8,
  parameter int unsigned WRAP_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_in,
  input  logic              phase_wrap,
  input  logic              run,
  input  logic [STEP_W-1:0] step_len,
  input  logic [1:0]        seq_len,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_slot,
  input  mask_t             cfg_mask,
  output logic              enable_square,
  output logic              enable_sawtooth,
  output logic              enable_triangle,
  output logic [1:0]        step_idx,
  output logic              pending
);

  // Timeout counter is sized to hold WRAP_TIMEOUT; at least one bit when no wait is wanted
  localparam int TO_W = (WRAP_TIMEOUT < 1) ? 1 : $clog2(WRAP_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(WRAP_TIMEOUT);

  state_e              r_state;
  state_e              w_state_next;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic [1:0]          r_nxt_idx;
  logic [1:0]          r_step_idx;
  mask_t               r_snap;
  mask_t               r_en;
  logic                r_pending;
  logic                r_cfg_ready;

  logic [STEP_W-1:0]   w_step_lim;
  logic [STEP_W-1:0]   w_step_inc;
  logic [TO_W-1:0]     w_to_inc;
  logic                w_step_done;
  logic                w_timeout;
  logic [1:0]          w_nxt;
  logic                w_wr_en;
  mask_t               w_rd_mask;

  // A step length of zero behaves as one tick per step
  assign w_step_lim  = (step_len == '0) ? STEP_W'(1) : step_len;
  // Both counters stop at all-ones instead of rolling over
  assign w_step_inc  = (&r_step_cnt) ? r_step_cnt : r_step_cnt + 1'b1;
  assign w_to_inc    = (&r_to_cnt) ? r_to_cnt : r_to_cnt + 1'b1;
  // ">=" so that a step_len lowered mid-step still ends the step on the next tick
  assign w_step_done = tick_in && (w_step_inc >= w_step_lim);
  assign w_timeout   = (WRAP_TIMEOUT == 0) || (tick_in && (w_to_inc >= TO_LIM));
  assign w_nxt       = next_slot(r_step_idx, seq_len);
  assign w_wr_en     = cfg_valid && r_cfg_ready;

  mixer_mask_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .IDX_W     (2)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (cfg_slot),
    .i_wr_mask (cfg_mask),
    .i_rd_idx  (w_nxt),
    .o_rd_mask (w_rd_mask)
  );

  // Next-state logic; dropping run always abandons the step back to IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (run) w_state_next = COUNT;
      COUNT:   if (!run) w_state_next = IDLE;
               else if (w_step_done) w_state_next = PENDING;
      PENDING: if (!run) w_state_next = IDLE;
               else if (phase_wrap || w_timeout) w_state_next = APPLY;
      APPLY:   w_state_next = run ? COUNT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register plus registered status flags derived from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pending   <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_pending   <= (w_state_next == PENDING);
      r_cfg_ready <= (w_state_next != APPLY);
    end
  end

  // Counters, snapshot of the upcoming mask, and the applied enables/step index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_step_cnt <= '0;
      r_to_cnt   <= '0;
      r_nxt_idx  <= '0;
      r_snap     <= '0;
      r_en       <= '0;
      r_step_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (run) r_step_cnt <= '0;
        end
        COUNT: begin
          if (run && tick_in) r_step_cnt <= w_step_inc;
          if (run && w_step_done) begin
            r_nxt_idx <= w_nxt;
            r_snap    <= w_rd_mask;
            r_to_cnt  <= '0;
          end
        end
        PENDING: begin
          if (tick_in) r_to_cnt <= w_to_inc;
        end
        APPLY: begin
          r_en       <= r_snap;
          r_step_idx <= r_nxt_idx;
          r_step_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign enable_square   = r_en[SQ];
  assign enable_sawtooth = r_en[SAW];
  assign enable_triangle = r_en[TRI];
  assign step_idx        = r_step_idx;
  assign pending         = r_pending;
  assign cfg_ready       = r_cfg_ready;

endmodule
